ofdm_sym_sched: RTL and testbench

- Multi-symbol RX sequencer between the 800-sample capture memory, the CP sync peak search and fft_r2dit_64.
- After a sync peak (d_peak) is known, it walks M_SYM consecutive OFDM symbols.
- For each symbol it issues 64 memory reads past the CP, pulses fft_start and streams the samples into the FFT.
- It waits for fft_done before starting the next symbol, so one FFT instance is time-shared across all symbols of the frame.

---
 rtl/ofdm_sym_sched_if.sv | 38 +++
 rtl/ofdm_sym_sched.sv | 164 ++++++++++++++++
 tb/tb_ofdm_sym_sched.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_sym_sched_if.sv
// Bus bundle for ofdm_sym_sched: frame control, capture-memory read port,
// FFT input stream and status. The master modport is the sequencer side.
//
// Handshake semantics: there is no back-pressure anywhere on this bus.
// start, peak_vld, fft_start, fft_done and done are single-cycle pulses
// qualified by the receiver's state. mem_rd_en qualifies mem_rd_addr, and
// read data returns exactly one cycle later. fft_in_vld qualifies
// fft_in_real/imag, which read as 0 whenever fft_in_vld is low.
interface ofdm_sym_sched_if;
  logic               start;
  logic               peak_vld;
  logic        [9:0]  d_peak;
  logic               mem_rd_en;
  logic        [9:0]  mem_rd_addr;
  logic signed [15:0] mem_rd_real;
  logic signed [15:0] mem_rd_imag;
  logic               fft_start;
  logic               fft_in_vld;
  logic signed [15:0] fft_in_real;
  logic signed [15:0] fft_in_imag;
  logic               fft_done;
  logic        [3:0]  sym_idx;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    input  start, peak_vld, d_peak, mem_rd_real, mem_rd_imag, fft_done,
    output mem_rd_en, mem_rd_addr, fft_start, fft_in_vld, fft_in_real,
           fft_in_imag, sym_idx, busy, done, err
  );

  modport slave (
    output start, peak_vld, d_peak, mem_rd_real, mem_rd_imag, fft_done,
    input  mem_rd_en, mem_rd_addr, fft_start, fft_in_vld, fft_in_real,
           fft_in_imag, sym_idx, busy, done, err
  );
endinterface

// File: rtl/ofdm_sym_sched.sv
// Multi-symbol RX sequencer. After a sync peak it walks M_SYM OFDM symbols,
// skipping the CP of each, reading N samples from capture memory into one
// shared FFT and waiting for fft_done before the next symbol.
// Optional macro OFDM_SCHED_TIMEOUT_EN adds a fft_done watchdog (TO_CYC).
// state_dbg exposes the FSM state for checkers.
module ofdm_sym_sched #(
  parameter int N      = 64,
  parameter int G      = 16,
  parameter int M_SYM  = 3,
`ifdef OFDM_SCHED_TIMEOUT_EN
  parameter int LEN    = 800,
  parameter int TO_CYC = 1023
`else
  parameter int LEN    = 800
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  ofdm_sym_sched_if.master bus,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_PEAK = 3'd1,
    ST_CHECK     = 3'd2,
    ST_LAUNCH    = 3'd3,
    ST_FEED      = 3'd4,
    ST_WAIT_FFT  = 3'd5
  } state_t;

  localparam int          KW       = $clog2(N) + 1;
  localparam logic [10:0] G11      = 11'(G);
  localparam logic [10:0] STEP     = 11'(N + G);
  localparam logic [10:0] LAST_OFF = 11'(N - 1);
  localparam logic [10:0] LIM      = 11'(LEN - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [3:0]  SYM_LAST = 4'(M_SYM - 1);

  state_t          state;
  logic [10:0]     base;
  logic [KW-1:0]   k;
  logic [3:0]      sym_q;
  logic            rd_en_q;
  logic            vld_q;
  logic            fft_start_q;
  logic            done_q;
  logic            err_q;
  logic [10:0]     addr_sum;
  logic [10:0]     last_addr;

`ifdef OFDM_SCHED_TIMEOUT_EN
  localparam logic [9:0] WD_LAST = 10'(TO_CYC - 1);
  logic [9:0] wd;
`endif

  // base never exceeds LEN-N at a read, so 11 bits hold base+k and base+N-1
  assign addr_sum  = base + 11'(k);
  assign last_addr = base + LAST_OFF;

  // Sequencer FSM with all control outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      base        <= '0;
      k           <= '0;
      sym_q       <= '0;
      rd_en_q     <= 1'b0;
      fft_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef OFDM_SCHED_TIMEOUT_EN
      wd          <= '0;
`endif
    end else begin
      fft_start_q <= 1'b0;
      done_q      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            err_q <= 1'b0;
            state <= ST_WAIT_PEAK;
          end
        end
        ST_WAIT_PEAK: begin
          if (bus.peak_vld) begin
            base  <= {1'b0, bus.d_peak} + G11;
            sym_q <= '0;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // Abort the frame if this symbol would run past the capture buffer
          if (last_addr > LIM) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            fft_start_q <= 1'b1;
            k           <= '0;
            state       <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          rd_en_q <= 1'b1;
          state   <= ST_FEED;
        end
        ST_FEED: begin
          if (k == K_LAST) begin
            rd_en_q <= 1'b0;
            state   <= ST_WAIT_FFT;
`ifdef OFDM_SCHED_TIMEOUT_EN
            wd      <= '0;
`endif
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_WAIT_FFT: begin
          if (bus.fft_done) begin
            if (sym_q == SYM_LAST) begin
              done_q <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              sym_q <= sym_q + 1'b1;
              base  <= base + STEP;
              state <= ST_CHECK;
            end
          end
`ifdef OFDM_SCHED_TIMEOUT_EN
          // done lands TO_CYC cycles after entering WAIT_FFT
          else if (wd == WD_LAST) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Align the FFT valid with the one-cycle memory read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= 1'b0;
    else        vld_q <= rd_en_q;
  end

  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_en_q ? addr_sum[9:0] : 10'd0;
  assign bus.fft_start   = fft_start_q;
  assign bus.fft_in_vld  = vld_q;
  assign bus.fft_in_real = vld_q ? bus.mem_rd_real : 16'sd0;
  assign bus.fft_in_imag = vld_q ? bus.mem_rd_imag : 16'sd0;
  assign bus.sym_idx     = sym_q;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_ofdm_sym_sched.sv
// Self-checking bench for ofdm_sym_sched: directed frames with a 1-cycle
// latency memory model and an FFT model returning fft_done 200 cycles after
// each fft_start. Define OFDM_SCHED_TIMEOUT_EN to also cover the watchdog.
module tb_ofdm_sym_sched;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  ofdm_sym_sched_if bus();
  logic [2:0] state_dbg;
  logic       fft_done_m = 1'b0;
  logic       fft_done_s = 1'b0;
  assign bus.fft_done = fft_done_m | fft_done_s;

`ifdef OFDM_SCHED_TIMEOUT_EN
  ofdm_sym_sched #(.TO_CYC(50)) dut (
`else
  ofdm_sym_sched dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory / FFT models ----------------
  function automatic logic [15:0] mre(input logic [9:0] a);
    return 16'({6'd0, a}) ^ 16'hA5A5;
  endfunction
  function automatic logic [15:0] mim(input logic [9:0] a);
    return 16'h8000 + 16'({6'd0, a}) * 16'd5;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rd_real <= mre(bus.mem_rd_addr);
      bus.mem_rd_imag <= mim(bus.mem_rd_addr);
    end
  end

  localparam int FFT_LAT = 200;
  bit withhold = 1'b0;
  int fft_cnt  = 0;
  always @(posedge clk) begin
    #1;
    fft_done_m = 1'b0;
    if (!rst_n) fft_cnt = 0;
    else begin
      if (fft_cnt > 0) begin
        fft_cnt--;
        if (fft_cnt == 0) fft_done_m = 1'b1;
      end
      if (bus.fft_start && !withhold) fft_cnt = FFT_LAT;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] exp_q[$];
  int   n_fs, n_rd, n_done, launch_cyc, last_done_cyc, last_rd_cyc, done_cyc;
  bit   have_done, first_rd, prev_en;
  logic [9:0]  cur_dp;
  logic [10:0] exp_addr;
  logic [9:0]  first_addr [0:15];

  task automatic clear_mon(input logic [9:0] dp);
    n_fs = 0; n_rd = 0; n_done = 0; have_done = 0; first_rd = 0;
    cur_dp = dp; exp_q.delete();
    for (int i = 0; i < 16; i++) first_addr[i] = '0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0;
      exp_q.delete();
    end else begin
      if (fft_done_m) begin
        have_done = 1'b1;
        last_done_cyc = cyc;
      end
      if (bus.fft_start) begin
        n_fs++;
        if (have_done) check("done_to_start", 32'(cyc - last_done_cyc), 32'd2);
        check("sym_idx", 32'(bus.sym_idx), 32'(n_fs - 1));
        exp_addr   = 11'({1'b0, cur_dp}) + 11'd16 + 11'(80 * (n_fs - 1));
        launch_cyc = cyc;
        first_rd   = 1'b1;
      end
      if (bus.mem_rd_en) begin
        if (first_rd) begin
          check("start_to_rd", 32'(cyc - launch_cyc), 32'd1);
          if (n_fs >= 1 && n_fs <= 16) first_addr[n_fs-1] = bus.mem_rd_addr;
          first_rd = 1'b0;
        end
        check("rd_addr", 32'(bus.mem_rd_addr), 32'(exp_addr));
        exp_addr++;
        n_rd++;
        last_rd_cyc = cyc;
        exp_q.push_back({mre(bus.mem_rd_addr), mim(bus.mem_rd_addr)});
      end
      check("vld_dly", 32'(bus.fft_in_vld), 32'(prev_en));
      if (bus.fft_in_vld) begin
        if (exp_q.size() == 0) check("fft_in_extra", 32'd1, 32'd0);
        else check("fft_in", {bus.fft_in_real, bus.fft_in_imag}, exp_q.pop_front());
      end else begin
        check("fft_in_gate", {bus.fft_in_real, bus.fft_in_imag}, 32'd0);
      end
      prev_en = bus.mem_rd_en;
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    check({tag, "_ctl"}, {26'd0, bus.mem_rd_en, bus.fft_start, bus.fft_in_vld,
                          bus.busy, bus.done, bus.err}, 32'd0);
    check({tag, "_addr"}, 32'(bus.mem_rd_addr), 32'd0);
    check({tag, "_data"}, {bus.fft_in_real, bus.fft_in_imag}, 32'd0);
    check({tag, "_sym"}, 32'(bus.sym_idx), 32'd0);
  endtask

  // start pulse, confirm acceptance, then peak pulse
  task automatic kick(input logic [9:0] dp);
    clear_mon(dp);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("start_busy", 32'(bus.busy), 32'd1);
    check("start_err_clr", 32'(bus.err), 32'd0);
    bus.d_peak   = dp;
    bus.peak_vld = 1'b1;
    tick();
    bus.peak_vld = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int w = 0;
    int nd0 = n_done;
    while (n_done == nd0 && w < lim) begin
      tick();
      w++;
    end
    if (n_done == nd0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input logic [9:0] dp, input int nsym, input bit exp_err, input bit poke);
    kick(dp);
    if (poke) begin
      int w = 0;
      while (n_rd < 10 && w < 100) begin tick(); w++; end
      check("poke_in_feed", 32'(bus.mem_rd_en), 32'd1);
      bus.start  = 1'b1;
      fft_done_s = 1'b1;
      tick();
      bus.start  = 1'b0;
      fft_done_s = 1'b0;
      check("poke_err", 32'(bus.err), 32'd0);
    end
    wait_done(3000);
    repeat (4) tick();
    check("n_fft_start", 32'(n_fs), 32'(nsym));
    check("n_reads", 32'(n_rd), 32'(64 * nsym));
    check("n_done", 32'(n_done), 32'd1);
    check("err", 32'(bus.err), 32'(exp_err));
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.start = 1'b0; bus.peak_vld = 1'b0; bus.d_peak = '0;
    repeat (3) tick();
    chk_outputs_zero("reset");
    check("reset_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    tick();

    // nominal 3-symbol frame from d_peak=5: bursts at 21, 101, 181
    run_frame(10'd5, 3, 1'b0, 1'b0);
    check("burst0_base", 32'(first_addr[0]), 32'd21);
    check("burst1_base", 32'(first_addr[1]), 32'd101);
    check("burst2_base", 32'(first_addr[2]), 32'd181);
    check("last_addr", 32'(exp_addr - 11'd1), 32'd244);

    // base 716 passes, symbol 1 at 796 overflows the buffer
    run_frame(10'd700, 1, 1'b1, 1'b0);
    check("oor_base", 32'(first_addr[0]), 32'd716);
    check("oor_last_addr", 32'(exp_addr - 11'd1), 32'd779);

    // start and stray fft_done during FEED are ignored; err cleared by start
    run_frame(10'd5, 3, 1'b0, 1'b1);

    // start with peak_vld in the same IDLE cycle: peak is not taken
    clear_mon(10'd9);
    bus.start = 1'b1; bus.peak_vld = 1'b1; bus.d_peak = 10'd9;
    tick();
    bus.start = 1'b0; bus.peak_vld = 1'b0;
    repeat (5) tick();
    check("same_cyc_state", 32'(state_dbg), 32'd1);
    check("same_cyc_nostart", 32'(n_fs), 32'd0);
    bus.peak_vld = 1'b1;
    tick();
    bus.peak_vld = 1'b0;
    wait_done(3000);
    repeat (4) tick();
    check("same_cyc_nfs", 32'(n_fs), 32'd3);
    check("same_cyc_base", 32'(first_addr[0]), 32'd25);

    // reset at FEED k=30 of symbol 0
    kick(10'd5);
    begin
      int w = 0;
      while (!bus.mem_rd_en && w < 20) begin tick(); w++; end
    end
    repeat (30) tick();
    check("pre_rst_addr", 32'(bus.mem_rd_addr), 32'd51);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("mid_rst");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    run_frame(10'd5, 3, 1'b0, 1'b0);
    check("post_rst_base", 32'(first_addr[0]), 32'd21);

`ifdef OFDM_SCHED_TIMEOUT_EN
    // withheld fft_done: done 50 cycles after entering WAIT_FFT
    withhold = 1'b1;
    kick(10'd5);
    wait_done(1000);
    repeat (2) tick();
    check("wd_done_lat", 32'(done_cyc - last_rd_cyc), 32'd51);
    check("wd_err", 32'(bus.err), 32'd1);
    check("wd_nfs", 32'(n_fs), 32'd1);
    check("wd_n_done", 32'(n_done), 32'd1);
    withhold = 1'b0;
    run_frame(10'd5, 3, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
